// File: rtl/apb_master_mux_if.sv
// Request/response handshake and APB4 requester bus for apb_master_mux.
// master is the bridge's view; slave is the view of the client and the peripherals.
interface apb_master_mux_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2
);
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_write;
  logic [ADDR_W-1:0]              req_addr;
  logic [DATA_W-1:0]              req_wdata;
  logic [DATA_W/8-1:0]            req_strb;

  logic                           rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           rsp_err;

  logic [NUM_SLAVES-1:0]          PSEL;
  logic                           PENABLE;
  logic [ADDR_W-1:0]              PADDR;
  logic                           PWRITE;
  logic [DATA_W-1:0]              PWDATA;
  logic [DATA_W/8-1:0]            PSTRB;
  logic [NUM_SLAVES-1:0]          PREADY;
  logic [NUM_SLAVES*DATA_W-1:0]   PRDATA;
  logic [NUM_SLAVES-1:0]          PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_mux.sv
// APB4 requester bridge: valid/ready requests become SETUP/ACCESS transfers to one
// of NUM_SLAVES peripherals, with PSLVERR reporting, wait-state timeout and zero-gap chaining.
module apb_master_mux #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_master_mux_if.master bus
);
  localparam int SW     = $clog2(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [SW-1:0]         sel_idx;
  logic [SW-1:0]         req_idx;
  logic [NUM_SLAVES-1:0] req_sel;
  logic [DATA_W-1:0]     prdata_a [NUM_SLAVES];
  logic [DATA_W-1:0]     sel_rdata;
  logic                  sel_ready;
  logic                  sel_err;
  logic                  timeout_hit;
  logic                  done;
  logic                  req_rdy;
  logic                  accept;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
    assign prdata_a[i] = bus.PRDATA[i*DATA_W +: DATA_W];
  end

  // Only the slave latched at accept is listened to; the others are ignored.
  assign sel_rdata   = prdata_a[sel_idx];
  assign sel_ready   = bus.PREADY[sel_idx];
  assign sel_err     = bus.PSLVERR[sel_idx];

  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && (cnt == TO_LAST) && !sel_ready;
  assign done        = (state == ACCESS) && (sel_ready || timeout_hit);
  assign req_rdy     = (state == IDLE) || done;
  assign accept      = bus.req_valid && req_rdy;
  assign bus.req_ready = req_rdy;

  assign req_idx = bus.req_addr[ADDR_W-1 -: SW];

  always_comb begin
    req_sel          = '0;
    req_sel[req_idx] = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      cnt           <= '0;
      sel_idx       <= '0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
      bus.PSTRB     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      unique case (state)
        SETUP: begin
          bus.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            // A timeout completes like a normal transfer but forces an error and no data.
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= (sel_ready && !bus.PWRITE) ? sel_rdata : '0;
            bus.rsp_err   <= sel_ready ? sel_err : 1'b1;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Accepting overrides the release above, giving zero-gap back-to-back transfers.
      if (accept) begin
        bus.PADDR   <= bus.req_addr;
        bus.PWRITE  <= bus.req_write;
        if (bus.req_write) bus.PWDATA <= bus.req_wdata;
        bus.PSTRB   <= bus.req_write ? bus.req_strb : {STRB_W{1'b0}};
        bus.PSEL    <= req_sel;
        bus.PENABLE <= 1'b0;
        sel_idx     <= req_idx;
        state       <= SETUP;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_mux.sv
// Randomised scoreboard bench for apb_master_mux: a driver issues requests, a slave model
// answers with chosen wait states, and a monitor checks bus phases and responses.
module tb_apb_master_mux;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int NUM_SLAVES = 2;
  localparam int TIMEOUT    = 4;
  localparam int STRB_W     = DATA_W / 8;
  localparam int SW         = $clog2(NUM_SLAVES);

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_mux_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES)) bus ();

  apb_master_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .TIMEOUT(TIMEOUT)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    int                wt;     // ACCESS cycles the slave holds PREADY low
    bit                err;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] pwd;    // PWDATA expected on the bus for this transfer
  } txn_t;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    bit                err;
  } rsp_t;

  txn_t slv_q[$];
  txn_t mon_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] last_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_bus(input txn_t t);
    chk("psel",   bus.PSEL,   32'(1) << (t.addr >> (ADDR_W - SW)));
    chk("paddr",  bus.PADDR,  t.addr);
    chk("pwrite", bus.PWRITE, t.wr);
    chk("pstrb",  bus.PSTRB,  t.wr ? t.strb : '0);
    chk("pwdata", bus.PWDATA, t.pwd);
  endtask

  // Driver: must be entered on a negedge; returns on the negedge after acceptance.
  task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input logic [STRB_W-1:0] st, input int wt, input bit er,
                       input logic [DATA_W-1:0] rd);
    txn_t t;
    rsp_t e;
    bit   r;
    bit   ok;
    t.wr = wr; t.addr = a; t.wdata = wd; t.strb = st; t.wt = wt; t.err = er; t.rdata = rd;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_strb  = st;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #4;
      r = bus.req_ready;
      @(posedge PCLK);
      if (r) begin
        ok = 1'b1;
        if (wr) last_wd = wd;
        t.pwd = last_wd;
        e.rdata = (wr || wt >= TIMEOUT) ? '0 : rd;
        e.err   = (wt >= TIMEOUT) ? 1'b1 : er;
        slv_q.push_back(t);
        mon_q.push_back(t);
        rsp_q.push_back(e);
        break;
      end
      @(negedge PCLK);
    end
    if (!ok) begin
      fail("req_accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
    end
    @(negedge PCLK);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge PCLK);
  endtask

  // Slave model: garbage on every unselected lane, scripted answer on the selected one.
  initial begin
    txn_t s;
    int   sacc;
    int   idx;
    s = '{default: 0};
    sacc = 0;
    bus.PREADY  = '0;
    bus.PSLVERR = '0;
    bus.PRDATA  = '0;
    forever begin
      @(negedge PCLK);
      bus.PREADY  = NUM_SLAVES'($urandom);
      bus.PSLVERR = NUM_SLAVES'($urandom);
      bus.PRDATA  = (NUM_SLAVES*DATA_W)'($urandom);
      if (!PRESETn) begin
        sacc = 0;
        continue;
      end
      if (bus.PSEL != '0) begin
        idx = 0;
        for (int i = 0; i < NUM_SLAVES; i++) if (bus.PSEL[i]) idx = i;
        if (!bus.PENABLE) begin
          if (slv_q.size() > 0) s = slv_q.pop_front();
          sacc = 0;
        end else begin
          bus.PREADY[idx] = (sacc >= s.wt);
          if (sacc >= s.wt) bus.PSLVERR[idx] = s.err;
          bus.PRDATA[idx*DATA_W +: DATA_W] = s.rdata;
          sacc++;
        end
      end
    end
  end

  // Monitor: phase ordering, field stability, ACCESS length, response timing and content.
  initial begin
    txn_t c;
    rsp_t r;
    bit   have;
    bit   due;
    bit   prev_setup;
    int   cacc;
    int   cexp;
    have = 0; due = 0; prev_setup = 0; cacc = 0; cexp = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        have = 0; due = 0; prev_setup = 0;
        continue;
      end
      chk("rsp_timing", bus.rsp_valid, due);
      due = 0;
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected", 1, 0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, r.rdata);
          chk("rsp_err",   bus.rsp_err,   r.err);
        end
      end
      if (bus.PENABLE && bus.PSEL == '0) fail("penable_without_psel", 1, 0);
      if (bus.PSEL != '0 && !bus.PENABLE) begin
        if (prev_setup) fail("setup_length", 2, 1);
        prev_setup = 1;
        if (mon_q.size() == 0) begin
          fail("setup_unexpected", 1, 0);
          have = 0;
        end else begin
          c = mon_q.pop_front();
          have = 1;
          cacc = 0;
          cexp = (c.wt >= TIMEOUT) ? TIMEOUT : c.wt + 1;
          check_bus(c);
        end
      end else begin
        prev_setup = 0;
        if (bus.PSEL != '0 && bus.PENABLE) begin
          if (!have) fail("access_unexpected", 1, 0);
          else begin
            check_bus(c);
            if (cacc >= cexp) fail("access_overrun", cacc + 1, cexp);
            cacc++;
            if (cacc == cexp) due = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    #12;
    chk("rst_psel",      bus.PSEL,      0);
    chk("rst_penable",   bus.PENABLE,   0);
    chk("rst_paddr",     bus.PADDR,     0);
    chk("rst_pwrite",    bus.PWRITE,    0);
    chk("rst_pwdata",    bus.PWDATA,    0);
    chk("rst_pstrb",     bus.PSTRB,     0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_req_ready", bus.req_ready, 1);
    #10 PRESETn = 1'b1;
    @(negedge PCLK);

    // Directed scenarios
    issue(1'b1, 8'h12, 8'hA5, 1'b1, 0, 1'b0, 8'h00); idle(3);
    issue(1'b0, 8'h85, 8'h00, 1'b0, 3, 1'b0, 8'h3C); idle(3);
    issue(1'b1, 8'h01, 8'h5A, 1'b1, 0, 1'b0, 8'h00);
    issue(1'b0, 8'h81, 8'h00, 1'b0, 0, 1'b0, 8'hC3); idle(3);
    issue(1'b1, 8'h10, 8'h77, 1'b1, 0, 1'b1, 8'h00); idle(3);
    issue(1'b0, 8'h90, 8'h00, 1'b0, 6, 1'b0, 8'hEE); idle(2);
    issue(1'b0, 8'h90, 8'h00, 1'b0, 1, 1'b0, 8'h44); idle(3);

    // Random traffic, including chained requests and timeouts
    for (int k = 0; k < 150; k++) begin
      bit wr;
      int wt;
      wr = 1'(($urandom_range(0, 1)));
      wt = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2) : $urandom_range(0, 3);
      issue(wr, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom), wt,
            ($urandom_range(0, 3) == 0), DATA_W'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(8);

    // Reset asserted during ACCESS
    issue(1'b0, 8'h80, 8'h00, 1'b0, 3, 1'b0, 8'h11);
    bus.req_valid = 1'b0;
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_psel",      bus.PSEL,      0);
    chk("midrst_penable",   bus.PENABLE,   0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    rsp_q.delete();
    mon_q.delete();
    slv_q.delete();
    last_wd = '0;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("postrst_req_ready", bus.req_ready, 1);
    idle(4);
    issue(1'b0, 8'h05, 8'h00, 1'b0, 1, 1'b0, 8'h69); idle(1);
    issue(1'b1, 8'hF0, 8'h96, 1'b1, 2, 1'b0, 8'h00); idle(2);

    for (int n = 0; n < 50 && rsp_q.size() > 0; n++) @(negedge PCLK);
    if (rsp_q.size() != 0) fail("drain_rsp", rsp_q.size(), 0);
    if (mon_q.size() != 0) fail("drain_bus", mon_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised APB4 requester bridge: turns a simple valid/ready request interface into APB SETUP/ACCESS transfers to one of NUM_SLAVES peripherals (UART, GPIO, ...).
- Generalises the fixed 8-bit, two-slave master:
  - width and slave count are parameters;
  - adds PSTRB, PSLVERR reporting, a wait-state timeout and back-to-back transfers with no IDLE gap.

Parameters:
- ADDR_W, 8: PADDR width.
- DATA_W, 8: data width; multiple of 8, max 32.
- NUM_SLAVES, 2: power of two, 2..16. Slave index = req_addr[ADDR_W-1 -: log2(NUM_SLAVES)].
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on the edge where req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
- rsp_err  out  1  PSLVERR or timeout.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes.
- PREADY  in  NUM_SLAVES  per-slave ready.
- PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data; slave i at bits [i*DATA_W +: DATA_W].
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset: all outputs and state are cleared immediately, regardless of clock:
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - state=IDLE, wait counter=0.
- FSM states: IDLE, SETUP, ACCESS. All APB and rsp outputs are registered.
- Selected-slave signals: sel_ready = PREADY[idx], sel_err = PSLVERR[idx], sel_rdata = PRDATA slice idx, where idx is the registered slave index.
- req_ready is combinational: 1 in IDLE, or in ACCESS when (sel_ready | timeout_hit); 0 otherwise.
- On accept, at that edge:
  - register PADDR = req_addr and PWRITE = req_write;
  - PWDATA = req_wdata on writes, else hold its previous value;
  - PSTRB = req_strb on writes, 0 on reads;
  - PSEL = one-hot of idx, PENABLE = 0;
  - next state = SETUP.
- SETUP is always exactly one cycle. At its end PENABLE goes to 1, state goes to ACCESS and the wait counter clears. PADDR, PWRITE, PWDATA, PSTRB and PSEL hold stable through SETUP and ACCESS.
- ACCESS with sel_ready = 0:
  - counter increments;
  - timeout_hit = (TIMEOUT != 0) & (counter == TIMEOUT-1) & !sel_ready.
- ACCESS, completion (sel_ready = 1), at the edge:
  - rsp_valid = 1 for exactly one cycle;
  - rsp_rdata = sel_rdata on reads, 0 on writes;
  - rsp_err = sel_err.
  - If req_valid is also high, the new request is accepted at the same edge and the next state is SETUP (zero-gap back-to-back).
  - Otherwise PSEL = 0, PENABLE = 0 and state = IDLE.
- ACCESS, timeout_hit: identical to completion, but rsp_err = 1 and rsp_rdata = 0. PSEL and PENABLE drop; a slave that asserts PREADY later is ignored.
- Write latency is 2 cycles from accept to the last ACCESS cycle, plus slave wait states; rsp_valid asserts the cycle after that.
- Reset asserted mid-transfer: the bus is released immediately and no rsp_valid is generated for the aborted transfer.
- PREADY and PSLVERR of non-selected slaves are ignored. rsp_rdata and rsp_err hold their values between pulses.

Test Plan:
- Write, no wait states. Defaults; req addr 0x12, wdata 0xA5, strb 1. Expect:
  - PSEL=2'b01 for 2 cycles; PENABLE only in the 2nd cycle; PWDATA=0xA5, PSTRB=1;
  - rsp_valid the next cycle with rsp_err=0 and rsp_rdata=0.
- Read with wait states. Read addr 0x85; slave 1 holds PREADY low for 3 ACCESS cycles, then returns PRDATA=0x3C. Expect:
  - PSEL=2'b10, PSTRB=0;
  - ACCESS lasts 4 cycles, then rsp_valid with rsp_rdata=0x3C.
- Back-to-back. req_valid held high for write 0x01 then read 0x81, both with PREADY=1. Expect:
  - second SETUP immediately follows the first ACCESS, with no IDLE cycle;
  - PSEL goes from 01 to 10;
  - two rsp_valid pulses 2 cycles apart.
- Slave error. Write to slave 0 with PSLVERR=1 and PREADY=1 -> rsp_err=1 and rsp_valid pulses once.
- Timeout, TIMEOUT=4. PREADY stuck low. Expect:
  - exactly 4 ACCESS cycles, then PSEL=0;
  - rsp_valid with rsp_err=1 and rsp_rdata=0.
  - A subsequent normal transfer completes correctly.
- Reset mid-transfer. Assert PRESETn=0 asynchronously during ACCESS. Expect:
  - PSEL, PENABLE and rsp_valid go to 0 before the next PCLK edge;
  - after release, req_ready=1 and no stale response appears.
